mmio_halt_monitor: RTL

- Memory-mapped responder on the single-cycle RISC-V core's data-store bus; it consumes the core's store outputs (MemWrite, DataAdr, WriteData).
- Decodes two addresses:
  - TOHOST: the program reports completion and an exit code.
  - CONSOLE: the program emits bytes into a drainable FIFO.
- Counts cycles, captures the halting PC and flags a watchdog timeout, so benches and FPGA wrappers get an in-hardware end-of-program verdict instead of matching PC values.

---
 rtl/mmio_halt_monitor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mmio_halt_monitor.sv
// mmio_halt_monitor: watches core stores for TOHOST/CONSOLE, runs a console FIFO, cycle counter and watchdog.
// Optional store counter enabled by defining MMIO_HALT_MONITOR_STORECNT_EN.
`timescale 1ns/1ps
module mmio_halt_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0F00,
    parameter logic [31:0] CONSOLE_ADDR   = 32'h0000_0F04,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC,
    input  logic        con_ready,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic        con_overflow,
    output logic        halted,
    output logic        timeout,
    output logic        pass,
    output logic        fail,
    output logic [30:0] exit_code,
    output logic [31:0] halt_pc,
    output logic [31:0] cycle_count,
    output logic [31:0] store_count
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_t;

    state_t state_q, state_d;

    logic        running;
    logic        tohost_hit;
    logic        console_hit;
    logic        wd_hit;

    logic [30:0] exit_code_q;
    logic [31:0] halt_pc_q;
    logic [31:0] cycle_count_q;
    logic        overflow_q;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_next;
    logic [AW:0] occ_q, occ_after_pop;
    logic [7:0]  head_q, head_d;
    logic        fifo_empty, fifo_full;
    logic        do_pop, do_push, do_drop;

    assign running     = (state_q == ST_RUN);
    assign tohost_hit  = running && MemWrite && (DataAdr == TOHOST_ADDR) && WriteData[0];
    assign console_hit = running && MemWrite && (DataAdr == CONSOLE_ADDR);
    assign wd_hit      = running && (cycle_count_q == WD_LAST);

    // A completing TOHOST store on the watchdog cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (tohost_hit)
                    state_d = ST_HALTED;
                else if (wd_hit)
                    state_d = ST_TIMEOUT;
            end
            ST_HALTED:  state_d = ST_HALTED;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exit_code_q <= '0;
            halt_pc_q   <= '0;
        end else if (running && state_d == ST_HALTED) begin
            exit_code_q <= WriteData[31:1];
            halt_pc_q   <= PC;
        end else if (running && state_d == ST_TIMEOUT) begin
            exit_code_q <= '0;
            halt_pc_q   <= PC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_count_q <= '0;
        else if (running && cycle_count_q != 32'hFFFF_FFFF)
            cycle_count_q <= cycle_count_q + 32'd1;
    end

    assign fifo_empty    = (occ_q == '0);
    assign fifo_full     = (occ_q == OCC_FULL);
    assign do_pop        = !fifo_empty && con_ready;
    assign do_push       = console_hit && (!fifo_full || do_pop);
    assign do_drop       = console_hit && fifo_full && !do_pop;
    assign occ_after_pop = occ_q - (AW + 1)'(do_pop);
    assign rd_ptr_next   = rd_ptr_q + AW'(do_pop);

    // The head byte lives in its own register so con_data holds its last value once the FIFO drains.
    always_comb begin
        head_d = head_q;
        if (occ_after_pop != '0)
            head_d = fifo_mem[rd_ptr_next];
        else if (do_push)
            head_d = WriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr_q] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_next;
            if (do_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            occ_q  <= occ_after_pop + (AW + 1)'(do_push);
            head_q <= head_d;
            if (do_drop)
                overflow_q <= 1'b1;
        end
    end

`ifdef MMIO_HALT_MONITOR_STORECNT_EN
    logic [31:0] store_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            store_count_q <= '0;
        else if (running && MemWrite && store_count_q != 32'hFFFF_FFFF)
            store_count_q <= store_count_q + 32'd1;
    end

    assign store_count = store_count_q;
`else
    assign store_count = '0;
`endif

    assign con_valid    = !fifo_empty;
    assign con_data     = head_q;
    assign con_overflow = overflow_q;
    assign halted       = (state_q == ST_HALTED);
    assign timeout      = (state_q == ST_TIMEOUT);
    assign pass         = halted && (exit_code_q == '0);
    assign fail         = timeout || (halted && exit_code_q != '0);
    assign exit_code    = exit_code_q;
    assign halt_pc      = halt_pc_q;
    assign cycle_count  = cycle_count_q;

endmodule
